sps_arb: RTL and testbench

SPS_ARB -- requirements
Module: sps_arb

---
 rtl/sps_arb.sv | 98 +++++++++
 tb/tb_sps_arb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sps_arb.sv
// sps_arb: two-channel round-robin arbiter in front of a shared 8-bit
// serial-to-parallel deserializer. One byte per grant, delivered with a
// one-cycle wr strobe from the DONE state.
//
// state | meaning
// IDLE  | no transfer; arbitrate between pending requests
// SHIFT | 8 cycles, granted channel shifts one bit per cycle
// DONE  | one cycle, byte presented with wr=1; arbitrate again
module sps_arb #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0,
  input  logic       req1,
  input  logic       d0,
  input  logic       d1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] datao,
  output logic       chan,
  output logic       wr,
  output logic       busy,
  output logic [7:0] bcnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state, state_nxt;
  // sel holds the channel currently (or most recently) served; it doubles as
  // the round-robin history, so resetting it to 1 gives ch0 first priority.
  logic       sel, sel_nxt;
  logic [2:0] bitcnt;
  logic [7:0] shreg, byte_nxt;
  logic [2:0] idx;
  logic       din;

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, arbitration and bit-placement logic.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      IDLE, DONE: begin
        if (req0 || req1) begin
          state_nxt = SHIFT;
          if (req0 && req1) sel_nxt = ~sel;
          else              sel_nxt = req1;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (bitcnt == 3'd7) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase

    din      = sel ? d1 : d0;
    idx      = MSB_FIRST ? (3'd7 - bitcnt) : bitcnt;
    byte_nxt = shreg;
    byte_nxt[idx] = din;
  end

  assign gnt0 = (state == SHIFT) && !sel;
  assign gnt1 = (state == SHIFT) && sel;
  assign wr   = (state == DONE);
  assign busy = (state != IDLE);

  // Datapath: channel select, shift assembly, byte/channel/count capture.
  always_ff @(posedge clk) begin
    if (clr) begin
      sel    <= 1'b1;
      bitcnt <= 3'd0;
      shreg  <= 8'h00;
      datao  <= 8'h00;
      chan   <= 1'b0;
      bcnt   <= 8'h00;
    end else begin
      sel <= sel_nxt;
      if (state == SHIFT) begin
        shreg  <= byte_nxt;
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          datao <= byte_nxt;
          chan  <= sel;
          bcnt  <= bcnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sps_arb.sv
// tb_sps_arb: table-driven directed vectors, hand sequences for the
// multi-cycle corners, then randomized traffic against a transaction-level
// model (grant countdown plus byte accumulator).
module tb_sps_arb;

  logic       clk = 1'b0;
  logic       clr, req0, req1, d0, d1;
  logic       gnt0, gnt1, wr, busy, chan;
  logic [7:0] datao, bcnt;
  logic       gnt0_m, gnt1_m, wr_m, busy_m, chan_m;
  logic [7:0] datao_m, bcnt_m;

  sps_arb #(.MSB_FIRST(1'b0)) u_dut (
    .clk(clk), .clr(clr), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .datao(datao), .chan(chan), .wr(wr),
    .busy(busy), .bcnt(bcnt)
  );

  sps_arb #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clr(clr), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .gnt0(gnt0_m), .gnt1(gnt1_m), .datao(datao_m), .chan(chan_m), .wr(wr_m),
    .busy(busy_m), .bcnt(bcnt_m)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit use_model = 1'b0;

  // reference model state
  int         m_cnt = 0, m_owner = 0, m_last = 1, m_wr = 0, m_chan = 0, m_bcnt = 0;
  logic [7:0] m_acc_l = '0, m_acc_m = '0, m_datao = '0, m_datao_m = '0;

  typedef struct {
    logic clr, r0, r1, d0, d1;
    logic g0, g1, wr;
    logic [7:0] datao;
    logic chan;
    logic [7:0] bcnt;
    logic [7:0] datab;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  k;
    logic b;
    if (clr) begin
      m_cnt = 0; m_wr = 0; m_last = 1; m_datao = '0; m_datao_m = '0;
      m_chan = 0; m_bcnt = 0;
    end else if (m_cnt > 0) begin
      b = (m_owner == 1) ? d1 : d0;
      k = 8 - m_cnt;
      m_acc_l[k]     = b;
      m_acc_m[7 - k] = b;
      m_cnt--;
      m_wr = 0;
      if (m_cnt == 0) begin
        m_wr = 1;
        m_datao = m_acc_l;
        m_datao_m = m_acc_m;
        m_chan = m_owner;
        m_bcnt = (m_bcnt + 1) % 256;
      end
    end else begin
      m_wr = 0;
      if (req0 || req1) begin
        m_owner = (req0 && req1) ? (1 - m_last) : (req1 ? 1 : 0);
        m_last = m_owner;
        m_cnt = 8;
      end
    end
  endtask

  task automatic check_model();
    chk("gnt0",   gnt0,    (m_cnt > 0 && m_owner == 0));
    chk("gnt1",   gnt1,    (m_cnt > 0 && m_owner == 1));
    chk("wr",     wr,      m_wr);
    chk("busy",   busy,    (m_cnt > 0 || m_wr == 1));
    chk("datao",  datao,   m_datao);
    chk("chan",   chan,    m_chan);
    chk("bcnt",   bcnt,    m_bcnt);
    chk("datao_msb", datao_m, m_datao_m);
    chk("gnt_excl", gnt0 & gnt1, 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) check_model();
  endtask

  initial begin
    int nwr, ng, seen;
    logic [1:0] chseq[3];
    logic [7:0] bits;

    clr = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 1'b0; d1 = 1'b0;

    // directed table: reset with both requests, then one ch0 byte 1,0,1,1,0,0,1,0
    bits = 8'b0100_1101;
    tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 8'h00};
    tv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 8'h00};
    tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 8'h00};
    for (int i = 3; i <= 9; i++)
      tv[i] = '{1'b0, 1'b1, 1'b0, bits[i-3], 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 8'h00};
    tv[10] = '{1'b0, 1'b1, 1'b0, bits[7], 1'b1, 1'b0, 1'b0, 1'b1, 8'h4D, 1'b0, 8'd1, 8'hB2};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h4D, 1'b0, 8'd1, 8'hB2};

    for (int i = 0; i < 12; i++) begin
      clr = tv[i].clr; req0 = tv[i].r0; req1 = tv[i].r1; d0 = tv[i].d0; d1 = tv[i].d1;
      step();
      chk($sformatf("tv%0d_gnt0", i), gnt0, tv[i].g0);
      chk($sformatf("tv%0d_gnt1", i), gnt1, tv[i].g1);
      chk($sformatf("tv%0d_wr", i), wr, tv[i].wr);
      chk($sformatf("tv%0d_datao", i), datao, tv[i].datao);
      chk($sformatf("tv%0d_chan", i), chan, tv[i].chan);
      chk($sformatf("tv%0d_bcnt", i), bcnt, tv[i].bcnt);
      chk($sformatf("tv%0d_datao_msb", i), datao_m, tv[i].datab);
    end

    use_model = 1'b1;

    // contention from reset release: ch0, ch1, ch0
    clr = 1'b1; step(); clr = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    nwr = 0;
    for (int i = 0; i < 40 && nwr < 3; i++) begin
      d0 = 1'($urandom); d1 = 1'($urandom);
      step();
      if (wr) begin chseq[nwr] = {1'b0, chan}; nwr++; end
    end
    chk("contend_bytes", nwr, 3);
    if (nwr == 3) begin
      chk("contend_ch_a", chseq[0], 0);
      chk("contend_ch_b", chseq[1], 1);
      chk("contend_ch_c", chseq[2], 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // ch1 request dropped during its third gnt cycle
    req1 = 1'b1; ng = 0; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      d0 = 1'($urandom); d1 = 1'($urandom);
      step();
      if (gnt1) ng++;
      if (ng == 3) req1 = 1'b0;
      if (wr) begin seen = 1; chk("drop_chan", chan, 1); end
    end
    chk("drop_gnt_cycles", ng, 8);
    chk("drop_wr_seen", seen, 1);
    step();

    // reset during gnt0 cycle 5
    req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin d0 = 1'($urandom); step(); end
    chk("rst_mid_gnt0_before", gnt0, 1);
    clr = 1'b1;
    step();
    chk("rst_mid_gnt0", gnt0, 0);
    chk("rst_mid_wr", wr, 0);
    chk("rst_mid_datao", datao, 8'h00);
    chk("rst_mid_bcnt", bcnt, 8'h00);
    clr = 1'b0; req0 = 1'b0;
    step();

    // 256 back-to-back bytes, bcnt wraps
    req0 = 1'b1; nwr = 0;
    for (int i = 0; i < 3000 && nwr < 256; i++) begin
      d0 = 1'($urandom); d1 = 1'($urandom);
      step();
      if (wr) begin
        nwr++;
        if (nwr == 255) chk("wrap_255", bcnt, 255);
        if (nwr == 256) chk("wrap_0", bcnt, 0);
      end
    end
    chk("wrap_bytes", nwr, 256);
    req0 = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) req0 = 1'($urandom);
      if ($urandom_range(0, 3) == 0) req1 = 1'($urandom);
      d0 = 1'($urandom); d1 = 1'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
